conv_3x3_controller: RTL and testbench
======================================

Name: conv_3x3_controller

Overview:
- Address and PE-sequencing controller for a 3x3, stride-1, valid-padding convolution.
- It walks every output pixel and every 4-filter group. For each one it streams 4-channel IFM and weight fetch addresses into the shared IFM/weight buffers, drives the PE enable mask, and flags the final fetch of each accumulation.
- It sits beside the 1x1 controller and feeds the same 4-PE array.

Parameters:
- ADDR_W, 32, width of addr_ifm/addr_weight
- LANE, 4, channels (bytes) per fetch word; address step per fetch
- PE_NUM, 4, filters processed in parallel (width of PE_en/PE_finish)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cal_start  in  1  start pulse; sampled only in IDLE
- ifm_w  in  8  IFM width W (>=3)
- ifm_h  in  8  IFM height H (>=3)
- ifm_c  in  8  IFM channels C (multiple of 4, >=4)
- num_filter  in  8  filter count F (>=1)
- stall  in  1  downstream back-pressure; freezes the sequence
- addr_ifm  out  ADDR_W  IFM byte address of the current fetch
- addr_weight  out  ADDR_W  weight byte address of the current fetch
- addr_valid  out  1  addresses are valid this cycle
- PE_en  out  PE_NUM  active-filter mask for the current group
- PE_finish  out  PE_NUM  last-fetch flag (equals the mask) on the final fetch of a pixel/group
- busy  out  1  high from the first FETCH cycle until the DONE cycle
- done  out  1  one-cycle pulse after the last fetch

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation aborts immediately; no done pulse; the next cal_start restarts from the origin.
- Configuration inputs are latched on the accepted cal_start. Later changes are ignored until the next start. cal_start is ignored while busy.
- States: IDLE -> FETCH on cal_start. FETCH -> DONE after the last fetch. DONE -> IDLE unconditionally.
- Loop order, outermost to innermost:
  - oy 0..H-3
  - ox 0..W-3
  - group g 0..ceil(F/4)-1
  - ky 0..2
  - kx 0..2
  - c 0..C-4, step 4
- Addresses in FETCH, computed at 32 bits with no wrap for legal configs:
  - addr_ifm = ((oy+ky)*W + (ox+kx))*C + c
  - addr_weight = g*9*C + (ky*3+kx)*C + c
- Fetches per pixel/group: N = 9*C/4.
- Registered outputs: the first fetch's addresses appear with addr_valid=1 in the cycle after cal_start is sampled. After that, one fetch per unstalled cycle.
- PE_en is held for the whole group:
  - 4'b1111 for full groups.
  - For the last group with rem = F mod 4 != 0: low rem bits set (1->0001, 2->0011, 3->0111).
  - PE_en is 0 outside FETCH.
- PE_finish = PE_en on the fetch where ky=2, kx=2, c=C-4; 0 otherwise.
- stall:
  - stall=1 during FETCH holds all counters and addresses; addr_valid and PE_finish are 0; PE_en and busy are held.
  - The held fetch is reissued in the first cycle with stall=0.
  - stall in IDLE/DONE has no effect.
- done: asserted for exactly one cycle (state DONE), in the cycle after the final fetch is issued. busy=1 in that cycle and drops to 0 in the next one.
- Total addr_valid cycles = (H-2)*(W-2)*ceil(F/4)*N.
- Increments are incremental; no multipliers are required. Any implementation must match the formulas above exactly.

Test Plan:
- W=H=3, C=4, F=4, no stall:
  - 9 fetches; addr_ifm = addr_weight = 0,4,...,32.
  - PE_en=1111 throughout; PE_finish=1111 on the 9th fetch only.
  - done pulses the next cycle; busy is low the cycle after that.
- W=H=3, C=4, F=6:
  - 18 fetches.
  - Fetches 1-9: PE_en=1111, weight 0..32.
  - Fetches 10-18: PE_en=0011, weight 36..68, addr_ifm 0..32 repeated.
  - PE_finish=1111 on fetch 9; PE_finish=0011 on fetch 18.
- W=4, H=3, C=8, F=4:
  - 36 fetches (18 per pixel).
  - Pixel 0: first addrs 0,4 (c=0,4), then 8; its fetch 18 (ky=kx=2, c=4) has addr_ifm 84.
  - Pixel 1: starts at addr_ifm 8, addr_weight 0.
- Same config as test 1, stall=1 for 3 cycles at fetch 5:
  - addr_valid low for 3 cycles; addresses held at 16.
  - Fetch 5 is reissued after the stall; sequence and total count unchanged; done is delayed by 3 cycles.
- reset_n low at fetch 4, then cal_start:
  - All outputs 0 immediately on reset; no done pulse.
  - The restart produces the full 9-fetch sequence from address 0.
- cal_start pulsed again mid-run, with ifm_c changed:
  - The pulse is ignored; the original sequence completes unaltered with a single done.

Source files
------------

// File: rtl/conv_3x3_controller.sv
`default_nettype none
// ============================================================================
// conv_3x3_controller : IFM/weight fetch sequencer and PE mask for a 3x3 conv
// Revision: 1.0
// ============================================================================
module conv_3x3_controller #(
  parameter int ADDR_W = 32,
  parameter int LANE   = 4,
  parameter int PE_NUM = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cal_start,
  input  logic [7:0]        ifm_w,
  input  logic [7:0]        ifm_h,
  input  logic [7:0]        ifm_c,
  input  logic [7:0]        num_filter,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr_ifm,
  output logic [ADDR_W-1:0] addr_weight,
  output logic              addr_valid,
  output logic [PE_NUM-1:0] PE_en,
  output logic [PE_NUM-1:0] PE_finish,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0]        C_LANE    = 8'(LANE);
  localparam logic [7:0]        C_PE      = 8'(PE_NUM);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LANE);

  state_t              state_q, state_d;
  logic [7:0]          cfg_w_q, cfg_h_q, cfg_c_q, cfg_nf_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [7:0]          c_q, c_d, ox_q, ox_d, oy_q, oy_d, fleft_q, fleft_d;
  logic [1:0]          kx_q, kx_d, ky_q, ky_d;
  logic [ADDR_W-1:0]   ybase_q, ybase_d, pbase_q, pbase_d, rbase_q, rbase_d;
  logic [ADDR_W-1:0]   aifm_q, aifm_d, awt_q, awt_d;
  logic                valid_q, valid_d, fin_q, fin_d, busy_q, busy_d, done_q, done_d;
  logic [PE_NUM-1:0]   pe_en_q, pe_en_d;

  logic [15:0]         w_stride;
  logic                w_last_c, w_last_kx, w_last_ky, w_last_g, w_last_ox, w_last_oy;

  // Lane i is active while at least i+1 filters remain in the current group.
  function automatic logic [PE_NUM-1:0] f_mask(input logic [7:0] n);
    logic [PE_NUM-1:0] m;
    for (int i = 0; i < PE_NUM; i++) begin
      m[i] = (32'(n) > i);
    end
    return m;
  endfunction

  assign w_stride  = {8'd0, ifm_w} * {8'd0, ifm_c};
  assign w_last_c  = (c_q == cfg_c_q - C_LANE);
  assign w_last_kx = (kx_q == 2'd2);
  assign w_last_ky = (ky_q == 2'd2);
  assign w_last_g  = (fleft_q <= C_PE);
  assign w_last_ox = (ox_q == cfg_w_q - 8'd3);
  assign w_last_oy = (oy_q == cfg_h_q - 8'd3);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    fleft_d = fleft_q;
    ybase_d = ybase_q;
    pbase_d = pbase_q;
    rbase_d = rbase_q;
    aifm_d  = aifm_q;
    awt_d   = awt_q;
    valid_d = valid_q;
    fin_d   = fin_q;
    pe_en_d = pe_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          state_d = S_FETCH;
          c_d     = '0;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          fleft_d = num_filter;
          ybase_d = '0;
          pbase_d = '0;
          rbase_d = '0;
          aifm_d  = '0;
          awt_d   = '0;
          valid_d = 1'b1;
          fin_d   = 1'b0;
          pe_en_d = f_mask(num_filter);
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (!stall) begin
          // Channel and kx steps are contiguous in both buffers; weights stay
          // contiguous across groups of the same pixel as well.
          aifm_d = aifm_q + ADDR_STEP;
          awt_d  = awt_q + ADDR_STEP;
          if (!w_last_c) begin
            c_d = c_q + C_LANE;
          end else begin
            c_d = '0;
            if (!w_last_kx) begin
              kx_d = kx_q + 2'd1;
            end else begin
              kx_d = '0;
              if (!w_last_ky) begin
                ky_d    = ky_q + 2'd1;
                rbase_d = rbase_q + stride_q;
                aifm_d  = rbase_d;
              end else begin
                ky_d = '0;
                if (!w_last_g) begin
                  fleft_d = fleft_q - C_PE;
                  rbase_d = pbase_q;
                  aifm_d  = pbase_q;
                end else begin
                  fleft_d = cfg_nf_q;
                  awt_d   = '0;
                  if (!w_last_ox) begin
                    ox_d    = ox_q + 8'd1;
                    pbase_d = pbase_q + ADDR_W'(cfg_c_q);
                  end else begin
                    ox_d = '0;
                    if (!w_last_oy) begin
                      oy_d    = oy_q + 8'd1;
                      ybase_d = ybase_q + stride_q;
                      pbase_d = ybase_d;
                    end else begin
                      state_d = S_DONE;
                      valid_d = 1'b0;
                      done_d  = 1'b1;
                    end
                  end
                  rbase_d = pbase_d;
                  aifm_d  = pbase_d;
                end
              end
            end
          end
          pe_en_d = (state_d == S_DONE) ? '0 : f_mask(fleft_d);
          fin_d   = (state_d == S_FETCH) && (c_d == cfg_c_q - C_LANE) &&
                    (kx_d == 2'd2) && (ky_d == 2'd2);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      cfg_c_q  <= '0;
      cfg_nf_q <= '0;
      stride_q <= '0;
      c_q      <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      fleft_q  <= '0;
      ybase_q  <= '0;
      pbase_q  <= '0;
      rbase_q  <= '0;
      aifm_q   <= '0;
      awt_q    <= '0;
      valid_q  <= 1'b0;
      fin_q    <= 1'b0;
      pe_en_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && cal_start) begin
        cfg_w_q  <= ifm_w;
        cfg_h_q  <= ifm_h;
        cfg_c_q  <= ifm_c;
        cfg_nf_q <= num_filter;
        stride_q <= ADDR_W'(w_stride);
      end
      state_q <= state_d;
      c_q     <= c_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      fleft_q <= fleft_d;
      ybase_q <= ybase_d;
      pbase_q <= pbase_d;
      rbase_q <= rbase_d;
      aifm_q  <= aifm_d;
      awt_q   <= awt_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      pe_en_q <= pe_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A stalled cycle does not issue its fetch; it is reissued once stall drops.
  assign addr_ifm    = aifm_q;
  assign addr_weight = awt_q;
  assign addr_valid  = valid_q & ~stall;
  assign PE_en       = pe_en_q;
  assign PE_finish   = (fin_q & ~stall) ? pe_en_q : '0;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_3x3_controller.sv
`default_nettype none
// ============================================================================
// tb_conv_3x3_controller : scoreboard bench for conv_3x3_controller
// Revision: 1.0
// ============================================================================
module tb_conv_3x3_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cal_start;
  logic [7:0]  ifm_w, ifm_h, ifm_c, num_filter;
  logic        stall;
  logic [31:0] addr_ifm, addr_weight;
  logic        addr_valid;
  logic [3:0]  PE_en, PE_finish;
  logic        busy, done;

  conv_3x3_controller #(.ADDR_W(32), .LANE(4), .PE_NUM(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cal_start  (cal_start),
    .ifm_w      (ifm_w),
    .ifm_h      (ifm_h),
    .ifm_c      (ifm_c),
    .num_filter (num_filter),
    .stall      (stall),
    .addr_ifm   (addr_ifm),
    .addr_weight(addr_weight),
    .addr_valid (addr_valid),
    .PE_en      (PE_en),
    .PE_finish  (PE_finish),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ifm;
    logic [31:0] wt;
    logic [3:0]  pe;
    logic [3:0]  fin;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  logic exp_done  = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: direct evaluation of the address formulas.
  task automatic push_model(input int w, input int h, input int c, input int f);
    int ng;
    exp_t e;
    ng = (f + 3) / 4;
    for (int oy = 0; oy <= h - 3; oy++)
      for (int ox = 0; ox <= w - 3; ox++)
        for (int g = 0; g < ng; g++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              for (int ch = 0; ch <= c - 4; ch += 4) begin
                int rem;
                rem   = f - g * 4;
                e.ifm = 32'(((oy + ky) * w + (ox + kx)) * c + ch);
                e.wt  = 32'(g * 9 * c + (ky * 3 + kx) * c + ch);
                e.pe  = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
                e.fin = (ky == 2 && kx == 2 && ch == c - 4) ? e.pe : 4'h0;
                e.last = (oy == h - 3) && (ox == w - 3) && (g == ng - 1) &&
                         (ky == 2) && (kx == 2) && (ch == c - 4);
                sb.push_back(e);
              end
  endtask

  // Monitor: pops the scoreboard on every issued fetch and tracks done/busy.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_done  = 1'b0;
      prev_done = 1'b0;
    end else begin
      logic nxt_done;
      nxt_done = 1'b0;
      if (done || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
      if (done) done_cnt++;
      if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
      if (addr_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_fetch", 32'(addr_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("addr_ifm", addr_ifm, e.ifm);
          chk("addr_weight", addr_weight, e.wt);
          chk("PE_en", 32'(PE_en), 32'(e.pe));
          chk("PE_finish", 32'(PE_finish), 32'(e.fin));
          chk("busy_in_fetch", 32'(busy), 32'd1);
          nxt_done = e.last;
        end
      end else if (PE_finish !== 4'h0) begin
        chk("PE_finish_idle", 32'(PE_finish), 32'd0);
      end
      prev_done = done;
      exp_done  = nxt_done;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int w, input int h, input int c, input int f);
    push_model(w, h, c, f);
    ifm_w      = 8'(w);
    ifm_h      = 8'(h);
    ifm_c      = 8'(c);
    num_filter = 8'(f);
    cal_start  = 1'b1;
    cyc();
    cal_start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 500) begin
      cyc();
      k++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    cyc();
    cyc();
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    cal_start  = 1'b0;
    stall      = 1'b0;
    ifm_w      = 8'd0;
    ifm_h      = 8'd0;
    ifm_c      = 8'd0;
    num_filter = 8'd0;
    repeat (3) cyc();
    chk("rst_addr_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr_ifm", addr_ifm, 32'd0);
    chk("rst_addr_weight", addr_weight, 32'd0);
    chk("rst_PE_en", 32'(PE_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Single group, single pixel.
    start(3, 3, 4, 4);
    wait_done("t1");

    // Partial last group (F=6 -> mask 0011).
    start(3, 3, 4, 6);
    wait_done("t2");

    // Two output pixels, two channel words per tap.
    start(4, 3, 8, 4);
    wait_done("t3");

    // Stall for three cycles on fetch 5.
    start(3, 3, 4, 4);
    repeat (4) cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(addr_valid), 32'd0);
      chk("stall_addr_ifm", addr_ifm, 32'd16);
      chk("stall_PE_en", 32'(PE_en), 32'hF);
      chk("stall_busy", 32'(busy), 32'd1);
      cyc();
    end
    stall = 1'b0;
    wait_done("t4");

    // Reset at fetch 4 aborts, then a clean restart.
    start(3, 3, 4, 4);
    repeat (3) cyc();
    reset_n = 1'b0;
    #1;
    chk("abort_addr_valid", 32'(addr_valid), 32'd0);
    chk("abort_addr_ifm", addr_ifm, 32'd0);
    chk("abort_PE_en", 32'(PE_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    start(3, 3, 4, 4);
    wait_done("t5");

    // A second start mid-run with a different channel count is ignored.
    start(3, 3, 4, 4);
    repeat (3) cyc();
    ifm_c     = 8'd8;
    cal_start = 1'b1;
    cyc();
    cal_start = 1'b0;
    wait_done("t6");
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
